crop_top: RTL and testbench



---
 rtl/crop_pkg.sv | 33 +++
 rtl/crop_bbox_scan.sv | 116 +++++++++++
 rtl/crop_top.sv | 234 +++++++++++++++++++++++
 tb/tb_crop_top.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/crop_pkg.sv
// Shared types, header layout constants and small arithmetic helpers for the BMP auto-crop engine.
package crop_pkg;

  localparam int         MEM_DEPTH = 65536;
  localparam int         ADDR_W    = $clog2(MEM_DEPTH);
  localparam logic [7:0] BG_VAL    = 8'hFF;

  localparam int OFF_FSIZE  = 2;
  localparam int OFF_PIXOFF = 10;
  localparam int OFF_DIB    = 14;
  localparam int OFF_W      = 18;
  localparam int OFF_H      = 22;
  localparam int OFF_PLANES = 26;
  localparam int OFF_BPP    = 28;
  localparam int OFF_IMG    = 34;
  localparam int HDR_LEN    = 54;

  typedef enum logic [2:0] {IDLE, HDR, SCAN, WHDR, WPIX, DONE} state_t;

  function automatic logic [31:0] triple(input logic [15:0] v);
    return ({16'd0, v} << 1) + {16'd0, v};
  endfunction

  // Row length in bytes, padded up to a 4-byte boundary.
  function automatic logic [31:0] stride_of(input logic [15:0] w);
    return (triple(w) + 32'd3) & ~32'd3;
  endfunction

  function automatic logic [7:0] byte_sel(input logic [31:0] v, input logic [1:0] i);
    return v[{i, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/crop_bbox_scan.sv
// Walks every pixel byte of the input image bottom-up and tracks the bounding box of
// non-background pixels. Reads are issued one byte per cycle; data returns one cycle later.
module crop_bbox_scan
  import crop_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] pix_off,
  input  logic [15:0] width,
  input  logic [15:0] height,
  input  logic [31:0] stride,
  input  logic [7:0]  rdata,
  output logic [31:0] addr,
  output logic        fin,
  output logic [15:0] min_x,
  output logic [15:0] max_x,
  output logic [15:0] min_y,
  output logic [15:0] max_y,
  output logic        found
);

  logic        run;
  logic [15:0] x, y;
  logic [1:0]  b;
  logic [31:0] row_base;
  logic        pv, plast, acc_bg;
  logic [15:0] px, py;
  logic [1:0]  pb;
  logic        last_issue, byte_bg, pix_bg;

  assign last_issue = (b == 2'd2) && (x == width - 16'd1) && (y == height - 16'd1);
  assign byte_bg    = (rdata == BG_VAL);
  assign pix_bg     = acc_bg && byte_bg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      run      <= 1'b0;
      x        <= '0;
      y        <= '0;
      b        <= '0;
      row_base <= '0;
      addr     <= '0;
      pv       <= 1'b0;
      plast    <= 1'b0;
      px       <= '0;
      py       <= '0;
      pb       <= '0;
      acc_bg   <= 1'b0;
      fin      <= 1'b0;
      min_x    <= '1;
      min_y    <= '1;
      max_x    <= '0;
      max_y    <= '0;
      found    <= 1'b0;
    end else if (start) begin
      run      <= (width != 16'd0) && (height != 16'd0);
      fin      <= (width == 16'd0) || (height == 16'd0);
      x        <= '0;
      y        <= '0;
      b        <= '0;
      row_base <= pix_off;
      addr     <= pix_off;
      pv       <= 1'b0;
      min_x    <= '1;
      min_y    <= '1;
      max_x    <= '0;
      max_y    <= '0;
      found    <= 1'b0;
    end else begin
      pv <= run;
      if (run) begin
        px    <= x;
        py    <= y;
        pb    <= b;
        plast <= last_issue;
        addr  <= addr + 32'd1;
        if (b != 2'd2) begin
          b <= b + 2'd1;
        end else begin
          b <= 2'd0;
          if (x != width - 16'd1) begin
            x <= x + 16'd1;
          end else begin
            x <= '0;
            // Jump over the row padding to the next row base.
            if (y != height - 16'd1) begin
              y        <= y + 16'd1;
              row_base <= row_base + stride;
              addr     <= row_base + stride;
            end else begin
              run <= 1'b0;
            end
          end
        end
      end
      if (pv) begin
        case (pb)
          2'd0:    acc_bg <= byte_bg;
          2'd1:    acc_bg <= acc_bg && byte_bg;
          default: begin
            if (!pix_bg) begin
              found <= 1'b1;
              if (px < min_x) min_x <= px;
              if (px > max_x) max_x <= px;
              if (py < min_y) min_y <= py;
              if (py > max_y) max_y <= py;
            end
            if (plast) fin <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/crop_top.sv
// BMP auto-crop engine: parses the header in readMem, finds the foreground bounding box,
// and writes a cropped 24-bit BMP (header + padded rows) into writeMem, then raises done.
//
// state | meaning
// IDLE  | one cycle after reset release
// HDR   | read and latch the 54 header bytes, validate bpp/height
// SCAN  | bbox scan of every input pixel
// WHDR  | accumulate img size and source row base, then write 54 header bytes
// WPIX  | copy cropped rows bottom-up with zero padding
// DONE  | output complete, hold until reset
module crop_top
  import crop_pkg::*;
(
  input  logic       CLOCK_50,
  input  logic [3:0] KEY,
  output logic       done
);

  logic [7:0] readMem  [MEM_DEPTH];
  logic [7:0] writeMem [MEM_DEPTH];

  logic   rst_n;
  state_t state, state_nx;

  logic [7:0]  hdr [HDR_LEN];
  logic [5:0]  hcnt, hidx, wcnt;
  logic        hv, hdr_last, hdr_ok;
  logic [7:0]  rdata, wdata, hbyte;
  logic [31:0] raddr, waddr;
  logic        we;

  logic [31:0] pix_off, stride, h32;
  logic [15:0] width, bpp;

  logic        scan_start, scan_fin, found;
  logic [31:0] scan_addr;
  logic [15:0] min_x, max_x, min_y, max_y;

  logic [15:0] wout, hout, img_cnt, base_cnt, rows_left;
  logic [31:0] sout, w3, min_x3, img, fsize, row_base, src, k, dst;
  logic        accum_busy, issue_done, d_valid, d_pad;
  logic        unused_bits;

  assign rst_n       = KEY[3];
  assign unused_bits = ^{KEY[2:0], raddr[31:ADDR_W], waddr[31:ADDR_W]};

  assign pix_off  = {hdr[OFF_PIXOFF+3], hdr[OFF_PIXOFF+2], hdr[OFF_PIXOFF+1], hdr[OFF_PIXOFF]};
  assign width    = {hdr[OFF_W+1], hdr[OFF_W]};
  assign h32      = {hdr[OFF_H+3], hdr[OFF_H+2], hdr[OFF_H+1], hdr[OFF_H]};
  assign bpp      = {hdr[OFF_BPP+1], hdr[OFF_BPP]};
  assign stride   = stride_of(width);
  assign hdr_last = hv && (hidx == 6'(HDR_LEN - 1));
  assign hdr_ok   = (bpp == 16'd24) && ($signed(h32) > 32'sd0);

  assign sout       = stride_of(wout);
  assign w3         = triple(wout);
  assign min_x3     = triple(min_x);
  assign fsize      = 32'(HDR_LEN) + img;
  assign accum_busy = (img_cnt != 16'd0) || (base_cnt != 16'd0);

  always_ff @(posedge CLOCK_50) begin
    rdata <= readMem[raddr[ADDR_W-1:0]];
  end

  always_ff @(posedge CLOCK_50) begin
    if (rst_n && we) writeMem[waddr[ADDR_W-1:0]] <= wdata;
  end

  always_ff @(posedge CLOCK_50) begin
    if (state == HDR && hv) hdr[hidx] <= rdata;
  end

  crop_bbox_scan u_scan (
    .clk     (CLOCK_50),
    .rst_n   (rst_n),
    .start   (scan_start),
    .pix_off (pix_off),
    .width   (width),
    .height  (h32[15:0]),
    .stride  (stride),
    .rdata   (rdata),
    .addr    (scan_addr),
    .fin     (scan_fin),
    .min_x   (min_x),
    .max_x   (max_x),
    .min_y   (min_y),
    .max_y   (max_y),
    .found   (found)
  );

  always_ff @(posedge CLOCK_50) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = HDR;
      HDR:  if (hdr_last) state_nx = hdr_ok ? SCAN : DONE;
      SCAN: if (scan_fin) state_nx = WHDR;
      WHDR: if (!accum_busy && wcnt == 6'(HDR_LEN - 1)) state_nx = found ? WPIX : DONE;
      WPIX: if (d_valid && issue_done) state_nx = DONE;
      DONE: state_nx = DONE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    done       = (state == DONE);
    scan_start = (state == HDR) && hdr_last && hdr_ok;
    raddr      = 32'd0;
    we         = 1'b0;
    waddr      = 32'd0;
    wdata      = 8'h00;
    case (state)
      HDR:  raddr = {26'd0, hcnt};
      SCAN: raddr = scan_addr;
      WHDR: if (!accum_busy) begin
        we    = 1'b1;
        waddr = {26'd0, wcnt};
        wdata = hbyte;
      end
      WPIX: begin
        raddr = src;
        we    = d_valid;
        waddr = dst;
        wdata = d_pad ? 8'h00 : rdata;
      end
      default: ;
    endcase
  end

  function automatic logic in_field(input logic [5:0] i, input int off, input int len);
    return (int'(i) >= off) && (int'(i) < off + len);
  endfunction

  // Fixed fields are regenerated; everything else is copied from the input header.
  always_comb begin
    hbyte = hdr[wcnt];
    if (wcnt == 6'd0)                       hbyte = 8'h42;
    else if (wcnt == 6'd1)                  hbyte = 8'h4D;
    else if (in_field(wcnt, OFF_FSIZE, 4))  hbyte = byte_sel(fsize, 2'(wcnt - 6'(OFF_FSIZE)));
    else if (in_field(wcnt, OFF_PIXOFF, 4)) hbyte = byte_sel(32'(HDR_LEN), 2'(wcnt - 6'(OFF_PIXOFF)));
    else if (in_field(wcnt, OFF_DIB, 4))    hbyte = byte_sel(32'd40, 2'(wcnt - 6'(OFF_DIB)));
    else if (in_field(wcnt, OFF_W, 4))      hbyte = byte_sel({16'd0, wout}, 2'(wcnt - 6'(OFF_W)));
    else if (in_field(wcnt, OFF_H, 4))      hbyte = byte_sel({16'd0, hout}, 2'(wcnt - 6'(OFF_H)));
    else if (in_field(wcnt, OFF_PLANES, 2)) hbyte = byte_sel(32'd1, 2'(wcnt - 6'(OFF_PLANES)));
    else if (in_field(wcnt, OFF_BPP, 2))    hbyte = byte_sel(32'd24, 2'(wcnt - 6'(OFF_BPP)));
    else if (in_field(wcnt, OFF_IMG, 4))    hbyte = byte_sel(img, 2'(wcnt - 6'(OFF_IMG)));
  end

  always_ff @(posedge CLOCK_50) begin
    if (!rst_n) begin
      hcnt       <= '0;
      hidx       <= '0;
      hv         <= 1'b0;
      wout       <= '0;
      hout       <= '0;
      img        <= '0;
      img_cnt    <= '0;
      base_cnt   <= '0;
      row_base   <= '0;
      wcnt       <= '0;
      src        <= '0;
      k          <= '0;
      rows_left  <= '0;
      issue_done <= 1'b0;
      d_valid    <= 1'b0;
      d_pad      <= 1'b0;
      dst        <= '0;
    end else begin
      hv      <= 1'b0;
      d_valid <= 1'b0;
      case (state)
        HDR: if (hcnt < 6'(HDR_LEN)) begin
          hv   <= 1'b1;
          hidx <= hcnt;
          hcnt <= hcnt + 6'd1;
        end
        SCAN: if (scan_fin) begin
          wout     <= found ? (max_x - min_x + 16'd1) : 16'd0;
          hout     <= found ? (max_y - min_y + 16'd1) : 16'd0;
          img_cnt  <= found ? (max_y - min_y + 16'd1) : 16'd0;
          base_cnt <= found ? min_y : 16'd0;
          img      <= '0;
          row_base <= pix_off;
          wcnt     <= '0;
        end
        WHDR: begin
          // img = H'*S' and source base = pixOff + minY*S, both by repeated addition.
          if (accum_busy) begin
            if (img_cnt != 16'd0) begin
              img     <= img + sout;
              img_cnt <= img_cnt - 16'd1;
            end
            if (base_cnt != 16'd0) begin
              row_base <= row_base + stride;
              base_cnt <= base_cnt - 16'd1;
            end
          end else begin
            wcnt <= wcnt + 6'd1;
            if (wcnt == 6'(HDR_LEN - 1)) begin
              src        <= row_base + min_x3;
              k          <= '0;
              rows_left  <= hout;
              issue_done <= 1'b0;
              dst        <= 32'(HDR_LEN);
            end
          end
        end
        WPIX: begin
          if (!issue_done) begin
            d_valid <= 1'b1;
            d_pad   <= (k >= w3);
            if (k == sout - 32'd1) begin
              k         <= '0;
              row_base  <= row_base + stride;
              src       <= row_base + stride + min_x3;
              rows_left <= rows_left - 16'd1;
              if (rows_left == 16'd1) issue_done <= 1'b1;
            end else begin
              k <= k + 32'd1;
              if (k < w3) src <= src + 32'd1;
            end
          end
          if (d_valid) dst <= dst + 32'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_crop_top.sv
// Bench for crop_top: builds BMP images, runs the engine, and compares writeMem against
// a direct arithmetic model of the crop.
module tb_crop_top;

  logic       CLOCK_50 = 1'b0;
  logic [3:0] KEY = 4'b0111;
  logic       done;

  crop_top dut (
    .CLOCK_50 (CLOCK_50),
    .KEY      (KEY),
    .done     (done)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int tests = 0;
  int fails = 0;

  logic [7:0] src  [0:65535];
  logic [7:0] expm [0:65535];
  int  exp_len = 0;
  bit  exp_writes;
  int  model_pix;
  int  img_w, img_h, img_off, img_stride, file_len;

  task automatic check(string nm, longint act, longint want);
    tests++;
    if (act != want) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, want, want);
    end
  endtask

  task automatic put32(int off, int v);
    for (int i = 0; i < 4; i++) src[off+i] = 8'(v >> (8*i));
  endtask

  function automatic int le16(int a);
    return int'({src[a+1], src[a]});
  endfunction

  function automatic int le32(int a);
    return int'({src[a+3], src[a+2], src[a+1], src[a]});
  endfunction

  task automatic new_image(int w, int h, int poff, int bpp);
    img_w = w; img_h = h; img_off = poff;
    img_stride = (3*w + 3) & ~3;
    file_len = (h > 0) ? poff + h*img_stride : poff;
    for (int i = 0; i < poff; i++) src[i] = 8'($urandom);
    src[0] = 8'h42; src[1] = 8'h4D;
    put32(2, file_len); put32(10, poff); put32(14, 40); put32(18, w); put32(22, h);
    src[26] = 8'd1; src[27] = 8'd0; src[28] = 8'(bpp); src[29] = 8'(bpp >> 8);
    put32(34, (h > 0) ? h*img_stride : 0);
    for (int y = 0; y < h; y++)
      for (int j = 0; j < img_stride; j++)
        src[poff + y*img_stride + j] = (j < 3*w) ? 8'hFF : 8'($urandom);
  endtask

  task automatic set_px(int x, int y, logic [7:0] bb, logic [7:0] gg, logic [7:0] rr);
    int a;
    a = img_off + y*img_stride + 3*x;
    src[a] = bb; src[a+1] = gg; src[a+2] = rr;
  endtask

  task automatic put_exp32(int off, int v);
    for (int i = 0; i < 4; i++) expm[off+i] = 8'(v >> (8*i));
  endtask

  // Expected output computed straight from the image: bbox by scanning all pixels,
  // output rows copied with zero padding. Invalid images leave the previous output.
  task automatic model();
    int poff, w, h32, h, bpp, s, mnx, mny, mxx, mxy, wo, ho, so, img, pos, a;
    bit fnd;
    poff = le32(10); w = le16(18); h32 = le32(22); bpp = le16(28);
    model_pix = 0;
    if (bpp != 24 || h32 <= 0) begin
      exp_writes = 1'b0;
      return;
    end
    exp_writes = 1'b1;
    h = h32 & 32'hFFFF;
    s = (3*w + 3) & ~3;
    model_pix = h*s;
    fnd = 1'b0; mnx = 0; mny = 0; mxx = 0; mxy = 0;
    for (int y = 0; y < h; y++)
      for (int x = 0; x < w; x++) begin
        a = poff + y*s + 3*x;
        if (!(src[a] == 8'hFF && src[a+1] == 8'hFF && src[a+2] == 8'hFF)) begin
          if (!fnd || x < mnx) mnx = x;
          if (!fnd || x > mxx) mxx = x;
          if (!fnd || y < mny) mny = y;
          if (!fnd || y > mxy) mxy = y;
          fnd = 1'b1;
        end
      end
    wo = fnd ? mxx - mnx + 1 : 0;
    ho = fnd ? mxy - mny + 1 : 0;
    so = (3*wo + 3) & ~3;
    img = ho*so;
    exp_len = 54 + img;
    for (int i = 0; i < 54; i++) expm[i] = src[i];
    expm[0] = 8'h42; expm[1] = 8'h4D;
    put_exp32(2, exp_len); put_exp32(10, 54); put_exp32(14, 40);
    put_exp32(18, wo); put_exp32(22, ho);
    expm[26] = 8'd1; expm[27] = 8'd0; expm[28] = 8'd24; expm[29] = 8'd0;
    put_exp32(34, img);
    pos = 54;
    if (fnd)
      for (int y = mny; y <= mxy; y++) begin
        for (int x = mnx; x <= mxx; x++)
          for (int c = 0; c < 3; c++) begin
            expm[pos] = src[poff + y*s + 3*x + c];
            pos++;
          end
        for (int p = 0; p < so - 3*wo; p++) begin
          expm[pos] = 8'h00;
          pos++;
        end
      end
  endtask

  task automatic run_image(string name, int lit_fsize, int lit_w, int lit_h, int abort_at);
    int cycles, budget;
    model();
    if (lit_fsize >= 0) check({name, " model fsize"}, exp_len, lit_fsize);
    for (int i = 0; i < file_len; i++) dut.readMem[i] = src[i];
    @(negedge CLOCK_50);
    KEY[3] = 1'b0;
    repeat (2) @(negedge CLOCK_50);
    check({name, " done in reset"}, done, 0);
    KEY[3] = 1'b1;
    if (abort_at > 0) begin
      repeat (abort_at) @(negedge CLOCK_50);
      KEY[3] = 1'b0;
      @(negedge CLOCK_50);
      check({name, " done after abort"}, done, 0);
      @(negedge CLOCK_50);
      KEY[3] = 1'b1;
    end
    budget = 60 + 2*model_pix + 2*(exp_writes ? exp_len : 0);
    cycles = 0;
    while (!done && cycles < budget) begin
      @(negedge CLOCK_50);
      cycles++;
    end
    check({name, " done within budget"}, done, 1);
    if (done) begin
      for (int i = 0; i < exp_len; i++)
        check($sformatf("%s byte %0d", name, i), dut.writeMem[i], expm[i]);
      if (lit_fsize >= 0)
        check({name, " out fsize"}, {dut.writeMem[5], dut.writeMem[4], dut.writeMem[3], dut.writeMem[2]}, lit_fsize);
      if (lit_w >= 0)
        check({name, " out width"}, {dut.writeMem[19], dut.writeMem[18]}, lit_w);
      if (lit_h >= 0)
        check({name, " out height"}, {dut.writeMem[23], dut.writeMem[22]}, lit_h);
      for (int i = 0; i < 3; i++) begin
        @(negedge CLOCK_50);
        check({name, " done held"}, done, 1);
      end
    end
  endtask

  initial begin
    int w, h, poff, n, x, y;
    logic [7:0] cb, cg, cr;

    new_image(8, 8, 54, 24);
    run_image("all_white", 54, 0, 0, 0);

    new_image(8, 8, 54, 24);
    set_px(3, 5, 8'h00, 8'h00, 8'h00);
    run_image("one_px", 58, 1, 1, 0);
    check("one_px pad byte", dut.writeMem[57], 0);

    new_image(8, 8, 54, 32);
    run_image("bpp32_no_write", -1, -1, -1, 0);

    new_image(8, -4, 54, 24);
    run_image("neg_height_no_write", -1, -1, -1, 0);

    new_image(32, 32, 54, 24);
    for (int yy = 4; yy <= 13; yy++)
      for (int xx = 11; xx <= 20; xx++) set_px(xx, yy, 8'h00, 8'h00, 8'h00);
    run_image("square_abort", 374, 10, 10, 300);

    new_image(4, 4, 54, 24);
    for (int yy = 1; yy <= 2; yy++)
      for (int xx = 0; xx < 4; xx++) set_px(xx, yy, 8'h00, 8'h00, 8'hFF);
    run_image("w4_red", 78, 4, 2, 0);
    check("w4_red first B", dut.writeMem[54], 8'h00);
    check("w4_red first R", dut.writeMem[56], 8'hFF);

    for (int it = 0; it < 30; it++) begin
      w = $urandom_range(1, 24);
      h = $urandom_range(1, 12);
      poff = 54 + (($urandom_range(0, 2) == 0) ? $urandom_range(1, 16) : 0);
      new_image(w, h, poff, 24);
      n = $urandom_range(0, 4);
      for (int j = 0; j < n; j++) begin
        x = $urandom_range(0, w - 1);
        y = $urandom_range(0, h - 1);
        case ($urandom_range(0, 3))
          0: begin cb = 8'($urandom); cg = 8'($urandom); cr = 8'($urandom); end
          1: begin cb = 8'hFF; cg = 8'hFF; cr = 8'h00; end
          2: begin cb = 8'h00; cg = 8'hFF; cr = 8'hFF; end
          default: begin cb = 8'hFF; cg = 8'hFE; cr = 8'hFF; end
        endcase
        set_px(x, y, cb, cg, cr);
      end
      run_image($sformatf("rand%0d", it), -1, -1, -1, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
